alu_muldiv: RTL

Parametrised datapath ALU for the single-cycle/multi-cycle CPU core.
- Logic and add/sub/compare ops resolve combinationally in the same cycle.
- Multiply, divide and remainder run on an iterative, one-bit-per-cycle engine with a start/busy/done handshake and architectural HI/LO registers.
- It replaces the earlier fixed-width ALU, whose product and quotient only updated on the falling clock edge and had no completion signal, so the control unit had no way to know when they were valid.

---
 rtl/alu_muldiv.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Datapath ALU: single-cycle logic/add/compare ops plus an iterative
// one-bit-per-cycle multiply/divide engine with architectural HI/LO registers.
module alu_muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   alucontrol,
  input  logic         start,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N:0]      acc_q, acc_d;
  logic [N-1:0]    mq_q, mq_d;
  logic [N-1:0]    opnd_q, opnd_d;
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d;

  logic            md_en, md_div, md_sgn;
  logic [N:0]      add_sum, rs, step_acc;
  logic [N-1:0]    step_mq;
  logic            ge;
  logic [2*N-1:0]  prod, prod_fix;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sgn);
    return (sgn && v[N-1]) ? -v : v;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    md_en  = 1'b0;
    md_div = 1'b0;
    md_sgn = 1'b0;
    case (alucontrol)
      4'b0010, 4'b1010: begin md_en = 1'b1; md_sgn = 1'b1; end
      4'b1100:          begin md_en = 1'b1; end
      4'b1000, 4'b1001: begin md_en = 1'b1; md_div = 1'b1; md_sgn = 1'b1; end
      4'b1101:          begin md_en = 1'b1; md_div = 1'b1; end
      default: ;
    endcase
  end

  // One engine step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    add_sum  = mq_q[0] ? acc_q + {1'b0, opnd_q} : acc_q;
    rs       = {acc_q[N-1:0], mq_q[N-1]};
    ge       = rs >= {1'b0, opnd_q};
    step_acc = {1'b0, add_sum[N:1]};
    step_mq  = {add_sum[0], mq_q[N-1:1]};
    if (is_div_q) begin
      step_acc = ge ? rs - {1'b0, opnd_q} : rs;
      step_mq  = {mq_q[N-2:0], ge};
    end
    prod     = {step_acc[N-1:0], step_mq};
    prod_fix = qneg_q ? -prod : prod;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (start && md_en) begin
          if (md_div && b == '0) begin
            lo_d    = '1;
            hi_d    = a;
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            count_d  = CW'(N);
            acc_d    = '0;
            mq_d     = mag(a, md_sgn);
            opnd_d   = mag(b, md_sgn);
            is_div_d = md_div;
            qneg_d   = md_sgn & (a[N-1] ^ b[N-1]);
            rneg_d   = md_sgn & a[N-1];
          end
        end
      end
      S_RUN: begin
        acc_d   = step_acc;
        mq_d    = step_mq;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          if (is_div_q) begin
            lo_d = qneg_q ? -step_mq : step_mq;
            hi_d = rneg_q ? -step_acc[N-1:0] : step_acc[N-1:0];
          end else begin
            hi_d = prod_fix[2*N-1:N];
            lo_d = prod_fix[N-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: engine working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    count_q  <= count_d;
    acc_q    <= acc_d;
    mq_q     <= mq_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
  end

  always_comb begin
    result = '0;
    case (alucontrol)
      4'b0001: result = a + b;
      4'b0011: result = a - b;
      4'b0100: result = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1011: result = {{(N-1){1'b0}}, a < b};
      4'b0101: result = a | b;
      4'b0110: result = a & b;
      4'b0111: result = a ^ b;
      4'b1111: result = ~(a | b);
      4'b0010, 4'b1100, 4'b1000, 4'b1101: result = lo_q;
      4'b1010, 4'b1001: result = hi_q;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
